// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: source-select and FSM
// encodings, datapath widths and the vector-load beat address helper.
package wb_pkg;

    localparam int WORD_W      = 32;
    localparam int VEC_W       = 128;
    localparam int VLOAD_BEATS = 4;
    localparam int BEAT_W      = $clog2(VLOAD_BEATS);

    typedef enum logic [1:0] {
        SEL_SALU  = 2'b00,
        SEL_SLOAD = 2'b01,
        SEL_VALU  = 2'b10,
        SEL_VLOAD = 2'b11
    } wb_sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        VLOAD  = 2'b01,
        VWRITE = 2'b10
    } wb_state_t;

    // Word address of a beat; the add is 32-bit so it wraps past 0xFFFFFFFF.
    function automatic logic [WORD_W-1:0] beat_addr(input logic [WORD_W-1:0] base,
                                                     input logic [BEAT_W-1:0] beat);
        return base + {{(WORD_W-BEAT_W-2){1'b0}}, beat, 2'b00};
    endfunction

endpackage

// File: rtl/vload_assembler.sv
// Vector-load helper: latches the base address, counts beats, drives the
// per-beat word address and collects the returned words into 128-bit lanes.
module vload_assembler
    import wb_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    active_i,
    input  logic [WORD_W-1:0]       base_i,
    input  logic [WORD_W-1:0]       word_i,
    output logic [WORD_W-1:0]       vld_addr_o,
    output logic                    last_beat_o,
    output logic [VEC_W-1:0]        vec_o
);

    logic [WORD_W-1:0]                     base_q;
    logic [BEAT_W-1:0]                     beat_q;
    logic [VLOAD_BEATS-1:0][WORD_W-1:0]    lanes_q;

    assign last_beat_o = active_i && (beat_q == BEAT_W'(VLOAD_BEATS - 1));
    assign vld_addr_o  = active_i ? beat_addr(base_q, beat_q) : base_q;

    // The final beat's word is merged straight in so the write can issue
    // on the edge that ends the last beat.
    always_comb begin
        vec_o = lanes_q;
        vec_o[int'(beat_q)*WORD_W +: WORD_W] = word_i;
    end

    // NOTE: the lane buffer is reset along with the control state so no stale
    // data from an aborted load can ever be observed; state uses <= only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q  <= '0;
            beat_q  <= '0;
            lanes_q <= '0;
        end else if (start_i) begin
            base_q <= base_i;
            beat_q <= '0;
        end else if (active_i) begin
            lanes_q[beat_q] <= word_i;
            beat_q          <= last_beat_o ? '0 : beat_q + 1'b1;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: routes scalar/vector results to the register files and
// sequences 4-beat vector loads. Optional forwarding port: WB_FORWARD_EN.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int SREG_AW = 4,
    parameter int VREG_AW = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [1:0]           sel_wb,
    input  logic                 reg_we_in,
    input  logic [SREG_AW-1:0]   rd_in,
    input  logic [VEC_W-1:0]     ALUoutput,
    input  logic [WORD_W-1:0]    data_output,
    input  logic [WORD_W-1:0]    vector_output,
    input  logic [WORD_W-1:0]    vld_base,
    output logic [WORD_W-1:0]    vld_addr,
    output logic                 stall,
    output logic                 sreg_we,
    output logic [SREG_AW-1:0]   sreg_waddr,
    output logic [WORD_W-1:0]    sreg_wdata,
    output logic                 vreg_we,
    output logic [VREG_AW-1:0]   vreg_waddr,
    output logic [VEC_W-1:0]     vreg_wdata
`ifdef WB_FORWARD_EN
    ,
    output logic                 fwd_valid,
    output logic [SREG_AW-1:0]   fwd_rd,
    output logic [WORD_W-1:0]    fwd_data
`endif
);

    wb_state_t              state_q, state_d;
    logic                   sreg_we_q, sreg_we_d;
    logic [SREG_AW-1:0]     sreg_waddr_q, sreg_waddr_d;
    logic [WORD_W-1:0]      sreg_wdata_q, sreg_wdata_d;
    logic                   vreg_we_q, vreg_we_d;
    logic [VREG_AW-1:0]     vreg_waddr_q, vreg_waddr_d;
    logic [VEC_W-1:0]       vreg_wdata_q, vreg_wdata_d;
    logic [VREG_AW-1:0]     ld_rd_q, ld_rd_d;

    logic                   accept;
    logic                   vl_start;
    logic                   vl_last;
    logic [VEC_W-1:0]       vl_vec;
    wb_sel_t                sel;

    assign sel    = wb_sel_t'(sel_wb);
    assign accept = (state_q == IDLE) && valid_in && reg_we_in;
    assign stall  = (state_q == VLOAD);

    vload_assembler u_vload (
        .clk         (clk),
        .reset       (reset),
        .start_i     (vl_start),
        .active_i    (stall),
        .base_i      (vld_base),
        .word_i      (vector_output),
        .vld_addr_o  (vld_addr),
        .last_beat_o (vl_last),
        .vec_o       (vl_vec)
    );

    // NOTE: every signal is defaulted first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        sreg_we_d    = 1'b0;
        sreg_waddr_d = sreg_waddr_q;
        sreg_wdata_d = sreg_wdata_q;
        vreg_we_d    = 1'b0;
        vreg_waddr_d = vreg_waddr_q;
        vreg_wdata_d = vreg_wdata_q;
        ld_rd_d      = ld_rd_q;
        vl_start     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (sel)
                        SEL_SALU, SEL_SLOAD: begin
                            // r0 is hardwired: the write is dropped, not redirected.
                            if (rd_in != '0) begin
                                sreg_we_d    = 1'b1;
                                sreg_waddr_d = rd_in;
                                sreg_wdata_d = (sel == SEL_SALU) ? ALUoutput[WORD_W-1:0]
                                                                 : data_output;
                            end
                        end
                        SEL_VALU: begin
                            vreg_we_d    = 1'b1;
                            vreg_waddr_d = rd_in[VREG_AW-1:0];
                            vreg_wdata_d = ALUoutput;
                        end
                        SEL_VLOAD: begin
                            vl_start = 1'b1;
                            ld_rd_d  = rd_in[VREG_AW-1:0];
                            state_d  = VLOAD;
                        end
                        default: ;
                    endcase
                end
            end
            VLOAD: begin
                if (vl_last) begin
                    vreg_we_d    = 1'b1;
                    vreg_waddr_d = ld_rd_q;
                    vreg_wdata_d = vl_vec;
                    state_d      = VWRITE;
                end
            end
            VWRITE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sreg_we_q    <= 1'b0;
            sreg_waddr_q <= '0;
            sreg_wdata_q <= '0;
            vreg_we_q    <= 1'b0;
            vreg_waddr_q <= '0;
            vreg_wdata_q <= '0;
            ld_rd_q      <= '0;
        end else begin
            state_q      <= state_d;
            sreg_we_q    <= sreg_we_d;
            sreg_waddr_q <= sreg_waddr_d;
            sreg_wdata_q <= sreg_wdata_d;
            vreg_we_q    <= vreg_we_d;
            vreg_waddr_q <= vreg_waddr_d;
            vreg_wdata_q <= vreg_wdata_d;
            ld_rd_q      <= ld_rd_d;
        end
    end

    assign sreg_we    = sreg_we_q;
    assign sreg_waddr = sreg_waddr_q;
    assign sreg_wdata = sreg_wdata_q;
    assign vreg_we    = vreg_we_q;
    assign vreg_waddr = vreg_waddr_q;
    assign vreg_wdata = vreg_wdata_q;

`ifdef WB_FORWARD_EN
    assign fwd_valid = sreg_we_q;
    assign fwd_rd    = sreg_waddr_q;
    assign fwd_data  = sreg_wdata_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases then randomized
// traffic compared against a transaction-level expectation model.
module tb_writeback_stage;

    localparam int SREG_AW = 4;
    localparam int VREG_AW = 3;

    logic               clk;
    logic               reset;
    logic               valid_in;
    logic [1:0]         sel_wb;
    logic               reg_we_in;
    logic [SREG_AW-1:0] rd_in;
    logic [127:0]       ALUoutput;
    logic [31:0]        data_output;
    logic [31:0]        vector_output;
    logic [31:0]        vld_base;
    logic [31:0]        vld_addr;
    logic               stall;
    logic               sreg_we;
    logic [SREG_AW-1:0] sreg_waddr;
    logic [31:0]        sreg_wdata;
    logic               vreg_we;
    logic [VREG_AW-1:0] vreg_waddr;
    logic [127:0]       vreg_wdata;
`ifdef WB_FORWARD_EN
    logic               fwd_valid;
    logic [SREG_AW-1:0] fwd_rd;
    logic [31:0]        fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    writeback_stage #(.SREG_AW(SREG_AW), .VREG_AW(VREG_AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .sel_wb        (sel_wb),
        .reg_we_in     (reg_we_in),
        .rd_in         (rd_in),
        .ALUoutput     (ALUoutput),
        .data_output   (data_output),
        .vector_output (vector_output),
        .vld_base      (vld_base),
        .vld_addr      (vld_addr),
        .stall         (stall),
        .sreg_we       (sreg_we),
        .sreg_waddr    (sreg_waddr),
        .sreg_wdata    (sreg_wdata),
        .vreg_we       (vreg_we),
        .vreg_waddr    (vreg_waddr),
        .vreg_wdata    (vreg_wdata)
`ifdef WB_FORWARD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [3:0] rand_rd();
        return ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    endfunction

    task automatic scramble_inputs();
        valid_in    = 1'($urandom);
        sel_wb      = 2'($urandom);
        reg_we_in   = 1'($urandom);
        rd_in       = 4'($urandom);
        ALUoutput   = rand128();
        data_output = $urandom;
        vld_base    = $urandom;
    endtask

    // One non-vector-load instruction; all driving/sampling at posedge+1.
    task automatic scalar_op(input logic v, input logic we, input logic [1:0] sel,
                             input logic [3:0] rd, input logic [127:0] alu,
                             input logic [31:0] dout);
        logic exp_s, exp_v;
        valid_in      = v;
        reg_we_in     = we;
        sel_wb        = sel;
        rd_in         = rd;
        ALUoutput     = alu;
        data_output   = dout;
        vector_output = $urandom;
        vld_base      = $urandom;
        exp_s = v && we && (sel == 2'd0 || sel == 2'd1) && (rd != 4'd0);
        exp_v = v && we && (sel == 2'd2);
        @(posedge clk); #1;
        check("s_sreg_we", 128'(sreg_we), 128'(exp_s));
        if (exp_s) begin
            check("s_sreg_waddr", 128'(sreg_waddr), 128'(rd));
            check("s_sreg_wdata", 128'(sreg_wdata), (sel == 2'd0) ? 128'(alu[31:0]) : 128'(dout));
        end
        check("s_vreg_we", 128'(vreg_we), 128'(exp_v));
        if (exp_v) begin
            check("s_vreg_waddr", 128'(vreg_waddr), 128'(rd[2:0]));
            check("s_vreg_wdata", vreg_wdata, alu);
        end
        check("s_stall", 128'(stall), 128'(0));
`ifdef WB_FORWARD_EN
        check("fwd_valid", 128'(fwd_valid), 128'(exp_s));
        if (exp_s) begin
            check("fwd_rd", 128'(fwd_rd), 128'(rd));
            check("fwd_data", 128'(fwd_data), (sel == 2'd0) ? 128'(alu[31:0]) : 128'(dout));
        end
`endif
        valid_in = 1'b0;
    endtask

    // Vector load; abort_beat >= 0 pulls reset low during that beat.
    task automatic vload_op(input logic [31:0] base, input logic [3:0] rd,
                            input logic [31:0] words [4], input int abort_beat);
        logic [127:0] exp_vec;
        logic [31:0]  exp_addr;
        exp_vec = '0;
        for (int b = 0; b < 4; b++) exp_vec = exp_vec | (128'(words[b]) << (32 * b));
        valid_in  = 1'b1;
        reg_we_in = 1'b1;
        sel_wb    = 2'd3;
        rd_in     = rd;
        vld_base  = base;
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) begin
            exp_addr = base + 32'(4 * b);
            check("vl_stall", 128'(stall), 128'(1));
            check("vl_addr", 128'(vld_addr), 128'(exp_addr));
            check("vl_sreg_we", 128'(sreg_we), 128'(0));
            check("vl_vreg_we", 128'(vreg_we), 128'(0));
            if (b == abort_beat) begin
                reset = 1'b0;
                #1;
                check("rst_stall", 128'(stall), 128'(0));
                check("rst_vreg_we", 128'(vreg_we), 128'(0));
                check("rst_sreg_we", 128'(sreg_we), 128'(0));
                check("rst_addr", 128'(vld_addr), 128'(0));
                check("rst_vwdata", vreg_wdata, 128'(0));
                check("rst_vwaddr", 128'(vreg_waddr), 128'(0));
                check("rst_swdata", 128'(sreg_wdata), 128'(0));
                check("rst_swaddr", 128'(sreg_waddr), 128'(0));
                valid_in = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    vector_output = $urandom;
                    @(posedge clk); #1;
                    check("post_rst_vreg_we", 128'(vreg_we), 128'(0));
                    check("post_rst_stall", 128'(stall), 128'(0));
                end
                return;
            end
            scramble_inputs();
            vector_output = words[b];
            @(posedge clk); #1;
        end
        check("vw_stall", 128'(stall), 128'(0));
        check("vw_vreg_we", 128'(vreg_we), 128'(1));
        check("vw_vreg_waddr", 128'(vreg_waddr), 128'(rd[2:0]));
        check("vw_vreg_wdata", vreg_wdata, exp_vec);
        check("vw_addr_hold", 128'(vld_addr), 128'(base));
        valid_in = 1'b0;
        @(posedge clk); #1;
        check("vw_pulse_end", 128'(vreg_we), 128'(0));
        check("vw_idle_stall", 128'(stall), 128'(0));
    endtask

    initial begin
        logic [31:0] w [4];
        logic [31:0] base;

        reset         = 1'b0;
        valid_in      = 1'b0;
        sel_wb        = 2'd0;
        reg_we_in     = 1'b0;
        rd_in         = '0;
        ALUoutput     = '0;
        data_output   = '0;
        vector_output = '0;
        vld_base      = '0;
        @(posedge clk); #1;
        check("reset_stall", 128'(stall), 128'(0));
        check("reset_sreg_we", 128'(sreg_we), 128'(0));
        check("reset_vreg_we", 128'(vreg_we), 128'(0));
        check("reset_vld_addr", 128'(vld_addr), 128'(0));
        check("reset_vreg_wdata", vreg_wdata, 128'(0));
        check("reset_sreg_wdata", 128'(sreg_wdata), 128'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        scalar_op(1'b1, 1'b1, 2'd0, 4'd5, 128'h1234, $urandom);
        scalar_op(1'b1, 1'b1, 2'd1, 4'd0, rand128(), 32'hDEAD);
        scalar_op(1'b1, 1'b0, 2'd2, 4'd4, rand128(), $urandom);
        scalar_op(1'b0, 1'b1, 2'd0, 4'd9, rand128(), $urandom);

        w[0] = 32'hA; w[1] = 32'hB; w[2] = 32'hC; w[3] = 32'hD;
        vload_op(32'h100, 4'd6, w, -1);
        check("vl_literal", vreg_wdata, 128'h0000000D_0000000C_0000000B_0000000A);

        for (int b = 0; b < 4; b++) w[b] = $urandom;
        vload_op(32'hFFFF_FFF8, 4'd2, w, -1);

        for (int b = 0; b < 4; b++) w[b] = $urandom;
        vload_op(32'h200, 4'd1, w, 2);
        scalar_op(1'b1, 1'b1, 2'd1, 4'd8, rand128(), 32'hCAFE_F00D);

        scalar_op(1'b1, 1'b1, 2'd2, 4'd7, rand128(), $urandom);
        scalar_op(1'b1, 1'b1, 2'd0, 4'd3, rand128(), $urandom);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 12) begin
                for (int b = 0; b < 4; b++) w[b] = $urandom;
                base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                                   : $urandom;
                vload_op(base, rand_rd(), w, -1);
            end else begin
                logic [1:0] sel;
                logic       we;
                sel = 2'($urandom);
                we  = 1'($urandom_range(0, 3) != 0);
                if (sel == 2'd3) we = 1'b0;
                scalar_op(1'($urandom_range(0, 4) != 0), we, sel, rand_rd(), rand128(), $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
